// File: rtl/aes_ct_writeback.sv
// Purpose: writes one captured 128-bit AES ciphertext block to the data cache as
//          four consecutive 32-bit words, always giving way to CPU stores.
// Latency: a block accepted at edge N is written in cycles N+1..N+4, done pulses at
//          N+5 and ct_ready returns at N+6; each CPU-stall cycle adds one cycle.
// Backpressure: ct_ready is high only in IDLE; writes stall for as long as cpu_wen != 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ct_valid/ct_ready     ciphertext handshake; ct_data word 0 is [127:96]
//   ct_base_addr          byte address of word 0, sampled on handshake (low 2 bits dropped)
//   cpu_wen               CPU byte enables; any nonzero bit blocks the AES write
//   wen_aes_d             word write strobe, with cipher_addr / cipher_text
//   busy, done            busy in WRITE/DONE; done pulses for one cycle after word 3
//   blk_count             completed-block counter (wraps)
module aes_ct_writeback #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ct_valid,
  output logic                 ct_ready,
  input  logic [127:0]         ct_data,
  input  logic [31:0]          ct_base_addr,
  input  logic [3:0]           cpu_wen,
  output logic                 wen_aes_d,
  output logic [31:0]          cipher_addr,
  output logic [31:0]          cipher_text,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] blk_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   state;
  logic [127:0] ct_buf;
  logic [31:0]  base;
  logic [1:0]   idx;
  logic [31:0]  cur_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ct_buf    <= '0;
      base      <= '0;
      idx       <= '0;
      blk_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ct_valid) begin
            ct_buf <= ct_data;
            base   <= {ct_base_addr[31:2], 2'b00};
            idx    <= '0;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Advance only on cycles the cache actually takes our word.
          if (wen_aes_d) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= S_DONE;
          end
        end
        S_DONE: begin
          blk_count <= blk_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_word = ct_buf[127:96];
    case (idx)
      2'd0: cur_word = ct_buf[127:96];
      2'd1: cur_word = ct_buf[95:64];
      2'd2: cur_word = ct_buf[63:32];
      2'd3: cur_word = ct_buf[31:0];
      default: cur_word = ct_buf[127:96];
    endcase
  end

  assign ct_ready  = (state == S_IDLE);
  assign busy      = (state == S_WRITE) || (state == S_DONE);
  assign done      = (state == S_DONE);
  // CPU stores own the cache port; the AES write simply waits.
  assign wen_aes_d = (state == S_WRITE) && (cpu_wen == 4'd0);
  // Address arithmetic is modulo 2^32, so blocks may straddle the top of memory.
  assign cipher_addr = (state == S_WRITE) ? (base + {28'd0, idx, 2'b00}) : 32'd0;
  assign cipher_text = (state == S_WRITE) ? cur_word : 32'd0;

endmodule

// File: doc/aes_ct_writeback.md
# aes_ct_writeback

Writeback stage between the AES core and the data cache's AES write port. Captures one 128-bit ciphertext block from the AES core via a valid/ready handshake and stores it as four 32-bit words into consecutive data-memory words through `wen_aes_d` / `cipher_addr` / `cipher_text`. It defers to CPU stores so both write paths never hit memory in the same cycle.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the completed-block counter.

Ports (reset: synchronous, active-high; clock: `clk`):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ct_valid`  in  1  AES core has a ciphertext block.
- `ct_ready`  out  1  block can accept a ciphertext this cycle.
- `ct_data`  in  128  ciphertext; bits [127:96] are word 0.
- `ct_base_addr`  in  32  byte address for word 0; sampled on handshake.
- `cpu_wen`  in  4  CPU byte write enables to the data cache; any nonzero bit means CPU store this cycle.
- `wen_aes_d`  out  1  word write strobe to the data cache.
- `cipher_addr`  out  32  byte address of the word being written.
- `cipher_text`  out  32  word being written.
- `busy`  out  1  high in WRITE or DONE.
- `done`  out  1  one-cycle pulse after the last word is written.
- `blk_count`  out  CNT_WIDTH  number of completed blocks.

## Operation
- States: IDLE, WRITE, DONE. Registers: `ct_buf` (128), `base` (32, with [1:0] forced to 00 on capture), `idx` (2), `blk_count`.
- IDLE: `ct_ready`=1. If `ct_valid`, latch `ct_data` and `ct_base_addr` and set `idx`=0, then go to WRITE. Otherwise stay.
- WRITE: `ct_ready`=0.
  - `cipher_addr` = `base` + 4·`idx`, modulo 2^32, so wrap past 0xFFFFFFFF is allowed.
  - `cipher_text` = `ct_buf` word `idx`: idx0=[127:96], idx1=[95:64], idx2=[63:32], idx3=[31:0].
  - `wen_aes_d` = (`cpu_wen`==0), combinational.
  - When `wen_aes_d`=1: `idx` increments. If `idx` was 3, go to DONE.
  - When `cpu_wen`≠0: stall. `idx` and state hold, and no write is issued. Stalls are unbounded.
- DONE: `done`=1 and `blk_count` increments (wraps at 2^CNT_WIDTH). Go to IDLE the next cycle. `ct_ready`=0.
- Outside WRITE: `wen_aes_d`=0, `cipher_addr`=0, `cipher_text`=0.
- `ct_data`/`ct_base_addr` changes after capture have no effect on the block in flight.

## Timing
- Reset values: state=IDLE, `idx`=0, `ct_buf`=0, `base`=0, `blk_count`=0. Outputs after reset: `ct_ready`=1, `busy`=0, `done`=0, `wen_aes_d`=0, `cipher_addr`=0, `cipher_text`=0.
- Handshake at edge N (with `ct_valid`=`ct_ready`=1):
  - cycles N+1..N+4: four writes, with no stalls.
  - cycle N+5: `done`=1.
  - cycle N+6: `ct_ready`=1.
- Each CPU-stall cycle in WRITE adds exactly one cycle to this schedule.
- Minimum period between accepted blocks: 6 cycles.
- The data cache commits the write at the rising edge that ends the cycle in which `wen_aes_d`=1.
- Reset mid-operation: takes effect at the next edge. The block is abandoned with no further writes, and `blk_count` clears.
- `ct_valid` during WRITE/DONE is ignored. The AES core holds it until `ct_ready`.

## Test plan
- Reset, then idle: `ct_ready`=1; `wen_aes_d`, `done`, `busy`, `blk_count` all 0 for 10 cycles.
- Single block, no CPU traffic: `ct_data`=0x00112233_44556677_8899AABB_CCDDEEFF, base 0x0000_1000 → writes (0x1000,0x00112233), (0x1004,0x44556677), (0x1008,0x8899AABB), (0x100C,0xCCDDEEFF) in cycles N+1..N+4; `done` at N+5; `blk_count`=1.
- CPU stall: same block, with `cpu_wen`=4'b0011 in cycles N+2 and N+3 → no write in those cycles; word 1 at N+4; `done` at N+7; no lost or duplicate words.
- Misaligned and wrapping base: base 0xFFFF_FFFA → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Back-to-back blocks with `ct_valid` held high: second handshake at N+6; `ct_valid` ignored while `busy`; `blk_count`=2 after both.
- Reset asserted at cycle N+2: no `wen_aes_d` after the reset edge; all outputs return to reset values; the next block writes normally from word 0.
